// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined datapath select/skid blocks.
//   DATA_W      default datapath width
//   skid_state_e occupancy of the two-entry skid register pair
//   sel_width() select width for an N-input mux (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;

    // Encoding mirrors (main_valid, skid_valid) so each bit reads naturally.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_e;

    // $clog2 returns 0 for a single input; a 2-input mux still needs one bit.
    function automatic int sel_width(input int num_in);
        if (num_in <= 2) begin
            return 1;
        end
        return $clog2(num_in);
    endfunction

endpackage

// File: rtl/mux_skid_nx1_skid_buffer_2.sv
// ---------------------------------------------------------------------------
// skid_buffer_2
// Two-entry valid/ready register pair. The main register drives the output;
// the skid register catches one word that arrives while the output stalls.
// The ready output is a flop, so upstream never sees a combinational path
// from the downstream ready.
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset (dominates flush_i)
//   flush_i      drop everything held; concurrent input is discarded
//   in_data_i    word offered by upstream
//   in_valid_i   upstream offers in_data_i
//   in_ready_o   buffer can take a word this cycle (registered)
//   out_data_o   oldest held word (keeps last value when drained)
//   out_valid_o  out_data_o is valid (registered)
//   out_ready_i  downstream takes out_data_o this cycle
// ---------------------------------------------------------------------------
module skid_buffer_2
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             vld_q;
    logic             ready_q;

    logic accept;
    logic consume;

    // ready_q is low only in FULL, so no accept can happen there.
    assign accept  = in_valid_i & ready_q;
    assign consume = vld_q & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            // Data registers are left alone: OUT keeps its last value.
            state_q <= SKID_EMPTY;
            vld_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        vld_q   <= 1'b1;
                        state_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && consume) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        skid_q  <= in_data_i;
                        ready_q <= 1'b0;
                        state_q <= SKID_FULL;
                    end else if (consume) begin
                        vld_q   <= 1'b0;
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (consume) begin
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= SKID_ONE;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                    vld_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_data_o  = main_q;
    assign out_valid_o = vld_q;

endmodule

// File: rtl/mux_skid_nx1.sv
// ---------------------------------------------------------------------------
// mux_skid_nx1
// N:1 operand-select mux feeding a two-entry skid buffer, used for
// writeback/forwarding selection between pipeline stages. The selected word
// is captured on a valid/ready handshake; out-of-range selects produce zero
// and set a sticky error flag.
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   in_i         flat inputs, input k = in_i[k*WIDTH +: WIDTH]
//   sel_i        input select, sampled with in_i on accept
//   in_valid_i   upstream offers in_i/sel_i
//   in_ready_o   block can accept this cycle (registered)
//   flush_i      discard all held data
//   out_o        selected data (registered)
//   out_valid_o  out_o holds valid data
//   out_ready_i  downstream consumes out_o this cycle
//   sel_err_o    sticky: an out-of-range select was accepted
// ---------------------------------------------------------------------------
module mux_skid_nx1
    import cpu_pkg::*;
#(
    parameter  int WIDTH  = DATA_W,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] in_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        out_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    sel_err_o
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic             accept;
    logic             sel_err_q;

    // Codes with no matching input leave sel_data at zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_data = in_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // With a power-of-two input count every code is legal.
    if ((1 << SEL_W) == NUM_IN) begin : g_no_oor
        assign sel_oor = 1'b0;
    end else begin : g_oor
        assign sel_oor = (32'(sel_i) >= 32'(NUM_IN));
    end

    assign accept = in_valid_i & in_ready_o;

    // Set on the accepting edge even when a flush discards the word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err_o = sel_err_q;

    skid_buffer_2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_data_i   (sel_data),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

endmodule
